// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// and presents the full result with a one-cycle done pulse.
module serial_subtractor #(
  parameter int size = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [size-1:0] a,
  input  logic [size-1:0] b,
  input  logic            bin,
  output logic            busy,
  output logic            done,
  output logic [size-1:0] diff,
  output logic            bout
);

  localparam int CW = $clog2(size + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(size - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  logic [size-1:0] a_sh_r;
  logic [size-1:0] b_sh_r;
  // Holds the size-1 result bits already produced; the final bit joins on the last edge.
  logic [size-2:0] res_sh_r;
  logic [CW-1:0]   cnt_r;
  logic            br_r;
  logic            busy_r;
  logic            done_r;
  logic [size-1:0] diff_r;
  logic            bout_r;

  logic            a_bit_s;
  logic            b_bit_s;
  logic            d_bit_s;
  logic            nbr_s;
  logic [size-1:0] res_next_s;
  logic            last_s;

  // Full-subtractor cell for the current bit and the next result-register image.
  always_comb begin
    a_bit_s    = a_sh_r[0];
    b_bit_s    = b_sh_r[0];
    d_bit_s    = a_bit_s ^ b_bit_s ^ br_r;
    nbr_s      = (~a_bit_s & b_bit_s) | (~a_bit_s & br_r) | (b_bit_s & br_r);
    res_next_s = {d_bit_s, res_sh_r};
    last_s     = (cnt_r == LAST_BIT);
  end

  // Control FSM, datapath shift registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      a_sh_r   <= {size{1'b0}};
      b_sh_r   <= {size{1'b0}};
      res_sh_r <= {(size-1){1'b0}};
      cnt_r    <= {CW{1'b0}};
      br_r     <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      diff_r   <= {size{1'b0}};
      bout_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_sh_r   <= a;
            b_sh_r   <= b;
            res_sh_r <= {(size-1){1'b0}};
            cnt_r    <= {CW{1'b0}};
            br_r     <= bin;
            busy_r   <= 1'b1;
            done_r   <= 1'b0;
            state_r  <= RUN;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          a_sh_r   <= {1'b0, a_sh_r[size-1:1]};
          b_sh_r   <= {1'b0, b_sh_r[size-1:1]};
          res_sh_r <= res_next_s[size-1:1];
          br_r     <= nbr_s;
          if (last_s) begin
            cnt_r   <= cnt_r;
            diff_r  <= res_next_s;
            bout_r  <= nbr_s;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            cnt_r   <= cnt_r + CW'(1);
            state_r <= RUN;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign diff = diff_r;
  assign bout = bout_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and exhaustive self-checking bench for serial_subtractor (size=6).
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [5:0] a;
  logic [5:0] b;
  logic       bin;
  logic       busy;
  logic       done;
  logic [5:0] diff;
  logic       bout;

  int n_vec = 0;
  int n_err = 0;
  int hold_bad = 0;
  int overlap_bad = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.size(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Caller must be away from a rising edge; returns at the negedge inside DONE.
  task automatic run_op(input logic [5:0] ta, input logic [5:0] tb_v, input logic tc,
                        output logic [5:0] rd, output logic rb, output int busy_cyc);
    logic [6:0] prev;
    bit         acc;
    bit         fin;
    prev     = {bout, diff};
    busy_cyc = 0;
    acc      = 1'b0;
    fin      = 1'b0;
    rd       = 6'd0;
    rb       = 1'b0;
    a = ta; b = tb_v; bin = tc; start = 1'b1;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(posedge clk); #1;
      if (busy) acc = 1'b1;
    end
    start = 1'b0;
    if (!acc) begin
      check("accept_timeout", 32'd0, 32'd1);
      return;
    end
    for (int k = 0; k < 40 && !fin; k++) begin
      @(negedge clk);
      if (busy && done) overlap_bad++;
      if (done) fin = 1'b1;
      else if (busy) begin
        busy_cyc++;
        if ({bout, diff} !== prev) hold_bad++;
      end
    end
    if (!fin) begin
      check("done_timeout", 32'd0, 32'd1);
      return;
    end
    rd = diff;
    rb = bout;
  endtask

  logic [5:0] rd;
  logic       rb;
  int         bc;
  int         pulses;
  int         t;
  int         cyc_q[$];

  initial begin
    rst_n = 1'b0; start = 1'b0; a = 6'd0; b = 6'd0; bin = 1'b0;
    #12;
    check("rst_busy", busy, 32'd0);
    check("rst_done", done, 32'd0);
    check("rst_diff", diff, 32'd0);
    check("rst_bout", bout, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Basic case with busy length and done width.
    run_op(6'd5, 6'd3, 1'b0, rd, rb, bc);
    check("v1_diff", rd, 32'd2);
    check("v1_bout", rb, 32'd0);
    check("v1_busy_cycles", bc, 32'd6);
    @(negedge clk);
    check("v1_done_width", done, 32'd0);

    run_op(6'd3, 6'd5, 1'b0, rd, rb, bc);
    check("v2_diff", rd, 32'd62);
    check("v2_bout", rb, 32'd1);
    run_op(6'd0, 6'd0, 1'b1, rd, rb, bc);
    check("v3_diff", rd, 32'd63);
    check("v3_bout", rb, 32'd1);
    run_op(6'd63, 6'd63, 1'b1, rd, rb, bc);
    check("v4_diff", rd, 32'd63);
    check("v4_bout", rb, 32'd1);
    run_op(6'd6, 6'd4, 1'b1, rd, rb, bc);
    check("v5_diff", rd, 32'd1);
    check("v5_bout", rb, 32'd0);
    @(negedge clk);

    // Start re-pulse and operand changes during RUN must be ignored.
    a = 6'd10; b = 6'd4; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    check("ign_accept", busy, 32'd1);
    start = 1'b0;
    @(negedge clk);
    a = 6'd1; b = 6'd2; bin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 6'd33;
    pulses = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        if (pulses == 1) begin rd = diff; rb = bout; end
      end
    end
    check("ign_pulses", pulses, 32'd1);
    check("ign_diff", rd, 32'd6);
    check("ign_bout", rb, 32'd0);

    // Asynchronous reset in the third RUN cycle.
    a = 6'd20; b = 6'd7; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 32'd0);
    check("arst_done", done, 32'd0);
    check("arst_diff", diff, 32'd0);
    check("arst_bout", bout, 32'd0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      if (done) pulses++;
    end
    check("arst_no_done", pulses, 32'd0);
    run_op(6'd20, 6'd7, 1'b0, rd, rb, bc);
    check("arst_after_diff", rd, 32'd13);
    check("arst_after_bout", rb, 32'd0);
    @(negedge clk);

    // start held for 20 cycles: one result every 8 cycles.
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      start = (i < 20); a = 6'd10; b = 6'd4; bin = 1'b0;
      @(negedge clk);
      if (busy && done) overlap_bad++;
      if (done) begin
        pulses++;
        cyc_q.push_back(i + 1);
        check("b2b_diff", diff, 32'd6);
        check("b2b_bout", bout, 32'd0);
      end
    end
    start = 1'b0;
    check("b2b_pulses", pulses, 32'd3);
    for (int i = 1; i < cyc_q.size(); i++)
      check("b2b_interval", cyc_q[i] - cyc_q[i-1], 32'd8);
    @(negedge clk);

    // Exhaustive sweep against an integer model.
    for (int ai = 0; ai < 64; ai++) begin
      for (int bi = 0; bi < 64; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          run_op(6'(ai), 6'(bi), 1'(ci), rd, rb, bc);
          t = ai - bi - ci;
          check($sformatf("exh a=%0d b=%0d bin=%0d", ai, bi, ci),
                {25'd0, rb, rd}, {25'd0, (t < 0) ? 1'b1 : 1'b0, t[5:0]});
        end
      end
    end

    check("diff_hold_in_run", hold_bad, 32'd0);
    check("busy_done_overlap", overlap_bad, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: size, default 6, operand and result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  request a new subtraction; sampled only in IDLE.
REQ-005 a  input  size  minuend; captured when start is accepted.
REQ-006 b  input  size  subtrahend; captured when start is accepted.
REQ-007 bin  input  1  borrow-in; captured when start is accepted.
REQ-008 busy  output  1  high while an operation is in progress (RUN state).
REQ-009 done  output  1  single-cycle pulse marking a valid new result.
REQ-010 diff  output  size  registered result, a - b - bin modulo 2^size.
REQ-011 bout  output  1  registered borrow-out; 1 iff a < b + bin, operands unsigned.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-013 IDLE: start=1 on an edge SHALL latch a, b and bin into internal shift registers, clear the bit counter, clear the running borrow to bin, and enter RUN.
REQ-014 IDLE: start=0 SHALL leave all state unchanged.
REQ-015 RUN: each edge SHALL process one bit, LSB first.
REQ-016 Per-bit difference SHALL be a_i ^ b_i ^ br.
REQ-017 Per-bit next borrow SHALL be (~a_i & b_i) | (~a_i & br) | (b_i & br).
REQ-018 Each RUN edge SHALL shift the difference bit into the result shift register MSB-ward and increment the counter.
REQ-019 The counter SHALL be ceil(log2(size+1)) bits wide and SHALL never wrap during an operation.
REQ-020 On the edge processing bit size-1, diff and bout SHALL be updated with the complete result and the FSM SHALL enter DONE.
REQ-021 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-022 Latency: with start accepted on edge E0, done SHALL be high for exactly the cycle following edge E(size), i.e. size cycles after acceptance.
REQ-023 busy SHALL be 1 only in RUN.
REQ-024 done SHALL be 1 only in DONE.
REQ-025 busy and done SHALL never be high together.
REQ-026 start in RUN or DONE SHALL be ignored and not queued.
REQ-027 Changes on a, b or bin after acceptance SHALL NOT affect the in-flight result.
REQ-028 diff and bout SHALL hold their last value between completions and SHALL NOT show intermediate bits during RUN.
REQ-029 Back-to-back use: a start held high continuously SHALL be accepted on the first IDLE edge after DONE, giving a throughput of one result per size+2 cycles.

Reset
REQ-030 rst_n=0 SHALL immediately, without waiting for a clock edge, force state IDLE, busy=0, done=0, diff=0, bout=0, and clear the counter, shift registers and running borrow.
REQ-031 Reset asserted during RUN or DONE SHALL abort the operation with no done pulse; diff and bout SHALL read 0.
REQ-032 After rst_n rises, the first rising edge with start=1 SHALL be accepted normally.

Verification (size=6)
REQ-033 a=5, b=3, bin=0, start pulsed one cycle -> busy high 6 cycles; then done pulses one cycle with diff=2, bout=0.
REQ-034 a=3, b=5, bin=0 -> diff=62 (6'b111110), bout=1; a=0, b=0, bin=1 -> diff=63, bout=1.
REQ-035 a=63, b=63, bin=1 -> diff=63, bout=1; a=6, b=4, bin=1 -> diff=1, bout=0.
REQ-036 start re-pulsed with new operands during RUN, and a changed mid-operation -> both ignored; result matches the originally captured operands; exactly one done pulse.
REQ-037 rst_n pulsed low at the 3rd RUN cycle -> busy, done, diff and bout go to 0 asynchronously; no done pulse; a fresh start afterwards yields the correct result.
REQ-038 start held high for 20 cycles with a=10, b=4, bin=0 -> done pulses every 8 cycles, each with diff=6, bout=0; a self-checking model compares all 8192 a/b/bin combinations.
